reg_file_sb: RTL and testbench

//  Parametrised multi-port register file: 2 write ports, 2 async read ports,
//  per-register busy scoreboard. Successor of the fixed 8x16 1W/2R file.

---
 rtl/reg_file_sb.sv | 115 +++++++++++
 tb/tb_reg_file_sb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Reads are combinational, with optional same-cycle write forwarding and an optional hardwired zero register.
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr0,
    input  logic [AW-1:0]    wr0_addr,
    input  logic [WIDTH-1:0] d_in0,
    input  logic             wr1,
    input  logic [AW-1:0]    wr1_addr,
    input  logic [WIDTH-1:0] d_in1,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic             busy_a,
    output logic             busy_b
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr0_en;
    logic wr1_en;
    logic rsv_en;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Requests aimed at a hardwired zero register are dropped before they reach any state.
    assign wr0_en = wr0 && !is_zero_reg(wr0_addr);
    assign wr1_en = wr1 && !is_zero_reg(wr1_addr);
    assign rsv_en = rsv && !is_zero_reg(rsv_addr);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = mem_q[i];
            busy_d[i] = busy_q[i];
            if (wr1_en && wr1_addr == AW'(i)) begin
                mem_d[i] = d_in1;
            end else if (wr0_en && wr0_addr == AW'(i)) begin
                mem_d[i] = d_in0;
            end
            // A new reservation outranks the completion of the previous producer.
            if (rsv_en && rsv_addr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end else if ((wr0_en && wr0_addr == AW'(i)) || (wr1_en && wr1_addr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             hit0;
        logic             hit1;
        logic             rsv_hit;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign addr    = (p == 0) ? rd_addr_a : rd_addr_b;
        assign hit0    = (BYPASS != 0) && wr0_en && (wr0_addr == addr);
        assign hit1    = (BYPASS != 0) && wr1_en && (wr1_addr == addr);
        assign rsv_hit = rsv_en && (rsv_addr == addr);

        // A forwarded write shows the post-edge busy state: clear unless re-reserved this cycle.
        always_comb begin
            data = mem_q[addr];
            busy = busy_q[addr];
            if (hit1) begin
                data = d_in1;
                busy = rsv_hit;
            end else if (hit0) begin
                data = d_in0;
                busy = rsv_hit;
            end
            if (is_zero_reg(addr)) begin
                data = '0;
                busy = 1'b0;
            end
        end
    end

    assign d_out_a = g_rd[0].data;
    assign d_out_b = g_rd[1].data;
    assign busy_a  = g_rd[0].busy;
    assign busy_b  = g_rd[1].busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two configurations (plain+bypass, zero-reg without bypass) on shared stimulus,
// checked every cycle against an array model, plus literal expectations for the key scenarios.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, wr0, wr1, rsv;
    logic [2:0]  wr0_addr, wr1_addr, rsv_addr, rd_addr_a, rd_addr_b;
    logic [15:0] d_in0, d_in1;
    logic [15:0] da0, db0, da1, db1;
    logic        ba0, bb0, ba1, bb1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit check_en = 1'b0;

    // Model state, index 0 = ZERO_REG 0 / BYPASS 1, index 1 = ZERO_REG 1 / BYPASS 0.
    logic [15:0] mem_m [2][8];
    logic        bsy_m [2][8];

    reg_file_sb #(.WIDTH(16), .AW(3), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset),
        .wr0(wr0), .wr0_addr(wr0_addr), .d_in0(d_in0),
        .wr1(wr1), .wr1_addr(wr1_addr), .d_in1(d_in1),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(da0), .d_out_b(db0), .busy_a(ba0), .busy_b(bb0)
    );

    reg_file_sb #(.WIDTH(16), .AW(3), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset),
        .wr0(wr0), .wr0_addr(wr0_addr), .d_in0(d_in0),
        .wr1(wr1), .wr1_addr(wr1_addr), .d_in1(d_in1),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(da1), .d_out_b(db1), .busy_a(ba1), .busy_b(bb1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cycle, act, exp);
        end
    endtask

    function automatic void exp_rd(input int k, input logic [2:0] a,
                                   output logic [15:0] d, output logic b);
        bit z, byp, h0, h1;
        z   = (k == 1);
        byp = (k == 0);
        h0  = wr0 && (wr0_addr == a);
        h1  = wr1 && (wr1_addr == a);
        if (z && a == 3'd0) begin
            d = 16'h0;
            b = 1'b0;
        end else if (byp && (h0 || h1)) begin
            d = h1 ? d_in1 : d_in0;
            b = rsv && (rsv_addr == a);
        end else begin
            d = mem_m[k][a];
            b = bsy_m[k][a];
        end
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) begin
                if (!reset) begin
                    mem_m[k][a] <= 16'h0;
                    bsy_m[k][a] <= 1'b0;
                end else if (!(k == 1 && a == 0)) begin
                    if (wr1 && wr1_addr == 3'(a))      mem_m[k][a] <= d_in1;
                    else if (wr0 && wr0_addr == 3'(a)) mem_m[k][a] <= d_in0;
                    if (rsv && rsv_addr == 3'(a))      bsy_m[k][a] <= 1'b1;
                    else if ((wr0 && wr0_addr == 3'(a)) || (wr1 && wr1_addr == 3'(a)))
                        bsy_m[k][a] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] ed;
        logic        eb;
        if (check_en) begin
            exp_rd(0, rd_addr_a, ed, eb);
            chk("dut0.d_out_a", da0, ed);
            chk("dut0.busy_a", 16'(ba0), 16'(eb));
            exp_rd(0, rd_addr_b, ed, eb);
            chk("dut0.d_out_b", db0, ed);
            chk("dut0.busy_b", 16'(bb0), 16'(eb));
            exp_rd(1, rd_addr_a, ed, eb);
            chk("dut1.d_out_a", da1, ed);
            chk("dut1.busy_a", 16'(ba1), 16'(eb));
            exp_rd(1, rd_addr_b, ed, eb);
            chk("dut1.d_out_b", db1, ed);
            chk("dut1.busy_b", 16'(bb1), 16'(eb));
        end
    end

    task automatic idle();
        wr0 = 1'b0; wr1 = 1'b0; rsv = 1'b0;
        wr0_addr = 3'd0; wr1_addr = 3'd0; rsv_addr = 3'd0;
        d_in0 = 16'h0; d_in1 = 16'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        repeat (2) next_cycle();
        reset = 1'b1;
        check_en = 1'b1;

        // Scatter some state, then hold reset for two cycles: everything must read back zero.
        for (int i = 0; i < 8; i++) begin
            wr0 = 1'b1; wr0_addr = 3'(i); d_in0 = 16'(16'hA500 + i);
            rsv = 1'b1; rsv_addr = 3'(7 - i);
            next_cycle();
        end
        idle();
        reset = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            @(negedge clk);
            chk("reset.d_out_a", da0, 16'h0);
            chk("reset.busy_b", 16'(bb0), 16'h0);
            next_cycle();
        end

        // Two ports writing different registers in one cycle.
        wr0 = 1'b1; wr0_addr = 3'd3; d_in0 = 16'h1234;
        wr1 = 1'b1; wr1_addr = 3'd5; d_in1 = 16'hBEEF;
        next_cycle();
        idle();
        rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        @(negedge clk);
        chk("dual_wr.a", da0, 16'h1234);
        chk("dual_wr.b", db0, 16'hBEEF);
        chk("dual_wr.dut1_b", db1, 16'hBEEF);
        next_cycle();

        // Collision on the same register: port 1 wins, forwarded only with bypass.
        wr0 = 1'b1; wr0_addr = 3'd2; d_in0 = 16'h1111;
        wr1 = 1'b1; wr1_addr = 3'd2; d_in1 = 16'h2222;
        rd_addr_a = 3'd2;
        @(negedge clk);
        chk("collide.bypass", da0, 16'h2222);
        chk("collide.nobypass", da1, 16'h0000);
        next_cycle();
        idle();
        @(negedge clk);
        chk("collide.stored0", da0, 16'h2222);
        chk("collide.stored1", da1, 16'h2222);
        next_cycle();

        // Scoreboard: reserve, clear by write, reserve and write together.
        rsv = 1'b1; rsv_addr = 3'd4; rd_addr_a = 3'd4;
        @(negedge clk);
        chk("rsv.same_cycle", 16'(ba0), 16'h0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rsv.busy0", 16'(ba0), 16'h1);
        chk("rsv.busy1", 16'(ba1), 16'h1);
        next_cycle();
        wr1 = 1'b1; wr1_addr = 3'd4; d_in1 = 16'h00AA;
        @(negedge clk);
        chk("clr.bypass_busy", 16'(ba0), 16'h0);
        chk("clr.bypass_data", da0, 16'h00AA);
        chk("clr.nobypass_busy", 16'(ba1), 16'h1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("clr.busy0", 16'(ba0), 16'h0);
        chk("clr.busy1", 16'(ba1), 16'h0);
        chk("clr.data1", da1, 16'h00AA);
        next_cycle();
        wr0 = 1'b1; wr0_addr = 3'd4; d_in0 = 16'h0BB0;
        rsv = 1'b1; rsv_addr = 3'd4;
        @(negedge clk);
        chk("rsvwr.bypass_busy", 16'(ba0), 16'h1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rsvwr.busy0", 16'(ba0), 16'h1);
        chk("rsvwr.busy1", 16'(ba1), 16'h1);
        chk("rsvwr.data0", da0, 16'h0BB0);
        next_cycle();

        // Register 0: hardwired zero in dut1, ordinary register in dut0.
        wr0 = 1'b1; wr0_addr = 3'd0; d_in0 = 16'hFFFF;
        rsv = 1'b1; rsv_addr = 3'd0; rd_addr_a = 3'd0;
        @(negedge clk);
        chk("zero.same_data", da1, 16'h0);
        chk("zero.same_busy", 16'(ba1), 16'h0);
        chk("zero.dut0_bypass", da0, 16'hFFFF);
        next_cycle();
        idle();
        @(negedge clk);
        chk("zero.data", da1, 16'h0);
        chk("zero.busy", 16'(ba1), 16'h0);
        chk("zero.dut0_data", da0, 16'hFFFF);
        chk("zero.dut0_busy", 16'(ba0), 16'h1);
        next_cycle();

        // Reset wins over a write and a reservation in the same cycle.
        reset = 1'b0;
        wr1 = 1'b1; wr1_addr = 3'd6; d_in1 = 16'h5555;
        rsv = 1'b1; rsv_addr = 3'd4;
        rd_addr_a = 3'd6; rd_addr_b = 3'd4;
        next_cycle();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.data_a", da0, 16'h0);
        chk("rst_mid.busy_b", 16'(bb0), 16'h0);
        chk("rst_mid.data_b", db0, 16'h0);
        next_cycle();

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 99) != 0);
            wr0       = 1'($urandom_range(0, 1));
            wr1       = 1'($urandom_range(0, 1));
            rsv       = ($urandom_range(0, 2) == 0);
            wr0_addr  = 3'($urandom_range(0, 7));
            wr1_addr  = ($urandom_range(0, 3) == 0) ? wr0_addr : 3'($urandom_range(0, 7));
            rsv_addr  = ($urandom_range(0, 3) == 0) ? wr1_addr : 3'($urandom_range(0, 7));
            d_in0     = 16'($urandom);
            d_in1     = 16'($urandom);
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr1_addr : 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 2) == 0) ? wr0_addr :
                        ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            next_cycle();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
